// File: rtl/bulb_pkg.sv
// bulb_pkg: shared debounce state encoding and press_evt bit positions for the switch panel.
package bulb_pkg;
    typedef enum logic [1:0] {RELEASED, ARM_PRESS, PRESSED, ARM_RELEASE} deb_state_t;
    localparam int IDX_MAIN = 0;
    localparam int IDX_SEL1 = 1;
    localparam int IDX_SEL2 = 2;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus press/release debounce FSM; press pulses on the accepting cycle.
module debounce_cell
    import bulb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic btn_s;
    deb_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    assign btn_s = sync[1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // Both arm states count stable cycles of their target level; any bounce restarts from scratch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press   = 1'b0;
        case (state)
            RELEASED: if (btn_s) begin
                state_n = ARM_PRESS;
                cnt_n   = CW'(1);
            end
            ARM_PRESS: if (!btn_s) begin
                state_n = RELEASED;
                cnt_n   = '0;
            end else if (cnt == LAST) begin
                state_n = PRESSED;
                cnt_n   = '0;
                press   = 1'b1;
            end else cnt_n = cnt + 1'b1;
            PRESSED: if (!btn_s) begin
                state_n = ARM_RELEASE;
                cnt_n   = CW'(1);
            end
            ARM_RELEASE: if (btn_s) begin
                state_n = PRESSED;
                cnt_n   = '0;
            end else if (cnt == LAST) begin
                state_n = RELEASED;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            default: begin
                state_n = RELEASED;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: rtl/switch_panel.sv
// switch_panel: debounced toggle switches S/S1/S2 from three raw buttons.
// Define SWITCH_PANEL_INTERLOCK_EN to make S1 and S2 mutually exclusive (sel1 wins ties).
module switch_panel
    import bulb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_main,
    input  logic       btn_sel1,
    input  logic       btn_sel2,
    output logic       S,
    output logic       S1,
    output logic       S2,
    output logic [2:0] press_evt
);
    logic [2:0] btn, press;
    logic s1_n, s2_n;
    assign btn[IDX_MAIN] = btn_main;
    assign btn[IDX_SEL1] = btn_sel1;
    assign btn[IDX_SEL2] = btn_sel2;
    for (genvar i = 0; i < 3; i++) begin : g_cell
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[i]),
            .press(press[i])
        );
    end
`ifdef SWITCH_PANEL_INTERLOCK_EN
    // A sel1 press swallows a simultaneous sel2 press; whichever select turns on clears the other.
    always_comb begin
        s1_n = press[IDX_SEL1] ? ~S1 : (press[IDX_SEL2] && !S2) ? 1'b0 : S1;
        s2_n = press[IDX_SEL1] ? (S1 ? S2 : 1'b0) : press[IDX_SEL2] ? ~S2 : S2;
    end
`else
    always_comb begin
        s1_n = S1 ^ press[IDX_SEL1];
        s2_n = S2 ^ press[IDX_SEL2];
    end
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S         <= 1'b0;
            S1        <= 1'b0;
            S2        <= 1'b0;
            press_evt <= 3'b000;
        end else begin
            S         <= S ^ press[IDX_MAIN];
            S1        <= s1_n;
            S2        <= s2_n;
            press_evt <= press;
        end
    end
endmodule

// File: tb/tb_switch_panel.sv
// tb_switch_panel: scoreboard bench for switch_panel with DEBOUNCE_CYCLES=4, either interlock build.
module tb_switch_panel;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_main = 1'b0;
    logic btn_sel1 = 1'b0;
    logic btn_sel2 = 1'b0;
    logic S, S1, S2;
    logic [2:0] press_evt;
    int passed = 0;
    int total = 0;
    logic [5:0] sb[$];
    logic [5:0] exp_v, obs;
    logic e1, e2;

    switch_panel #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_main (btn_main),
        .btn_sel1 (btn_sel1),
        .btn_sel2 (btn_sel2),
        .S        (S),
        .S1       (S1),
        .S2       (S2),
        .press_evt(press_evt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            rst_n = (k >= 3);
            sb.push_back(6'b000000);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL reset cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
    endtask

    task automatic test_main_hold();
        for (int k = 0; k < 28; k++) begin
            btn_main = (k < 20);
            sb.push_back({(k >= D + 1), 2'b00, (k == D + 1) ? 3'b001 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL main_hold cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
    endtask

    task automatic test_sel1_bounce();
        logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 24; k++) begin
            btn_sel1 = (k < 5) ? pat[k] : (k < 16);
            sb.push_back({1'b1, (k >= 10), 1'b0, (k == 10) ? 3'b010 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL sel1_bounce cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
    endtask

`ifdef SWITCH_PANEL_INTERLOCK_EN
    task automatic test_interlock();
        for (int k = 0; k < 16; k++) begin
            btn_sel2 = (k < 8);
            sb.push_back({1'b1, (k < 5), (k >= 5), (k == 5) ? 3'b100 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL interlock_sel2 cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
        for (int k = 0; k < 16; k++) begin
            btn_sel1 = (k < 8);
            btn_sel2 = (k < 8);
            sb.push_back({1'b1, (k >= 5), (k < 5), (k == 5) ? 3'b110 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL interlock_both cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
        e1 = 1'b1;
        e2 = 1'b0;
    endtask
`else
    task automatic test_independent();
        for (int k = 0; k < 16; k++) begin
            btn_sel2 = (k < 8);
            sb.push_back({1'b1, 1'b1, (k >= 5), (k == 5) ? 3'b100 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL independent_sel2 cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
        for (int k = 0; k < 16; k++) begin
            btn_sel1 = (k < 8);
            btn_sel2 = (k < 8);
            sb.push_back({1'b1, (k < 5), (k < 5), (k == 5) ? 3'b110 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL independent_both cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
        e1 = 1'b0;
        e2 = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_arm();
        for (int k = 0; k < 5; k++) begin
            btn_main = 1'b1;
            rst_n = (k < 4);
            sb.push_back((k < 4) ? {1'b1, e1, e2, 3'b000} : 6'b000000);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL reset_mid_arm cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            btn_main = (k < 8);
            sb.push_back({(k >= D + 1), 2'b00, (k == D + 1) ? 3'b001 : 3'b000});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs = {S, S1, S2, press_evt};
            total++;
            if (obs !== exp_v) $display("FAIL rearm_after_reset cyc %0d: got %b want %b", k, obs, exp_v);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_main_hold();
        test_sel1_bounce();
`ifdef SWITCH_PANEL_INTERLOCK_EN
        test_interlock();
`else
        test_independent();
`endif
        test_reset_mid_arm();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/switch_panel.md
# switch_panel

Front-end for the bulb switch inputs: converts three raw, bouncy momentary push-buttons into the clean, latched switch levels `S`, `S1`, `S2` that drive the bulb controller. Each button is synchronised and debounced, and each accepted press toggles its switch level. The block sits between the board pins and the bulb controller's inputs and is the only source of those switch levels.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised cycles required before a press or release is accepted. Legal range is ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_main`  in  1  raw main button, asynchronous, high = pressed.
- `btn_sel1`  in  1  raw select-1 button, asynchronous, high = pressed.
- `btn_sel2`  in  1  raw select-2 button, asynchronous, high = pressed.
- `S`  out  1  latched main switch level.
- `S1`  out  1  latched select-1 level.
- `S2`  out  1  latched select-2 level.
- `press_evt`  out  3  one-cycle accepted-press strobes, {sel2, sel1, main}.

## Operation
- Each button passes through a 2-flop synchroniser, producing `btn_s`.
- Each button has its own debounce FSM with states RELEASED, ARM_PRESS, PRESSED and ARM_RELEASE, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
- RELEASED: when `btn_s`=1, go to ARM_PRESS with cnt=1.
- ARM_PRESS:
  - `btn_s`=0: go to RELEASED and clear cnt.
  - `btn_s`=1 and cnt=DEBOUNCE_CYCLES-1: go to PRESSED and accept the press.
  - Otherwise cnt++.
- PRESSED / ARM_RELEASE: mirror image of the press path, with `btn_s`=0 as the stable condition. Acceptance returns the FSM to RELEASED and produces no event.
- Accepted press:
  - The matching `press_evt` bit is high for exactly one cycle.
  - The matching level output toggles.
- Bounces during either ARM state restart the count. Any glitch shorter than DEBOUNCE_CYCLES is invisible.
- Holding a button produces exactly one event. A new event requires a full accepted release first.
- Presses on different buttons are independent unless the interlock feature below is compiled in.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces:
  - all FSMs to RELEASED, with cnt=0;
  - both synchroniser flops to 0;
  - `S`=`S1`=`S2`=0 and `press_evt`=0.
- Reset mid-arming discards the partial count. A button still held after reset must complete a fresh DEBOUNCE_CYCLES press.
- Latency: let edge 0 be the first rising edge that samples the raw input high with the input stable thereafter. The level output and `press_evt` change after edge DEBOUNCE_CYCLES+1. For DEBOUNCE_CYCLES=4 that is edge 5.
- Outputs are registered. There is no combinational path from a `btn_*` input to any output.
- Events on several buttons in the same cycle are all processed in that cycle, subject to the interlock rules.

## Configuration
- Macro: `SWITCH_PANEL_INTERLOCK_EN`.
- Defined (interlock on):
  - An accepted sel1 press that drives `S1` to 1 forces `S2`=0.
  - An accepted sel2 press that drives `S2` to 1 forces `S1`=0.
  - If sel1 and sel2 are accepted in the same cycle, sel1 wins. The sel2 press is dropped, and `press_evt[2]` still pulses.
- Undefined: `S1` and `S2` toggle independently, so `S1`=`S2`=1 is reachable.
- `S` is unaffected by the macro in both cases.

## Structure
- Package `bulb_pkg` holds:
  - the debounce state enum `deb_state_t` (RELEASED, ARM_PRESS, PRESSED, ARM_RELEASE);
  - the `press_evt` bit-index constants IDX_MAIN=0, IDX_SEL1=1, IDX_SEL2=2.
- Sub-module `debounce_cell` contains the synchroniser, FSM and counter, and outputs a press strobe. It is instantiated three times.
- The top level holds the toggle and interlock logic and the output registers.

## Test plan
- Reset with all buttons idle, DEBOUNCE_CYCLES=4: after reset `S`=`S1`=`S2`=0 and `press_evt`=000.
- `btn_main` held high for 20 cycles: `S` rises after edge 5, `press_evt`=001 for exactly one cycle, and there is no further event while the button is held.
- `btn_sel1` bounced 1,0,1,1,0 and then stable high: no event during the bounce; one toggle of `S1` occurs 4 stable synchronised cycles after the final rise.
- Interlock compiled in, `S1`=1, then a sel2 press: `S2`=1 and `S1`=0 in the same cycle. Simultaneous sel1+sel2 press with `S1`=0: `S1`=1, `S2`=0, `press_evt`=110.
- Interlock compiled out, with sel1 and sel2 each pressed once: `S1`=`S2`=1.
- `rst_n` asserted during ARM_PRESS while `btn_main` is still held: no event. After release of reset, the button must stay held another DEBOUNCE_CYCLES before `S` toggles.
